// File: rtl/card_terminal.sv
// card_terminal: customer card + bank model feeding a vending machine.
// Define CARD_TERM_REFUND_EN to re-credit an approved cost on FAILED_TRAN.
module card_terminal #(
  parameter int START_BALANCE = 20,
  parameter int BAL_W         = 8,
  parameter int AUTH_DELAY    = 2,
  parameter int ARM_TIMEOUT   = 12
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             CARD_INSERT,
  input  logic             TOPUP,
  input  logic [3:0]       TOPUP_AMT,
  input  logic [2:0]       COST,
  input  logic             VEND,
  input  logic             FAILED_TRAN,
  input  logic             INVALID_SELL,
  output logic             CARD_IN,
  output logic             VALID_TRAN,
  output logic             DECLINED,
  output logic             BUSY,
  output logic [BAL_W-1:0] BALANCE
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    AUTH,
    DONE
  } state_t;

  localparam int CW      = 8;
  localparam int DONE_TO = 16;

  typedef logic [BAL_W-1:0] bal_t;
  typedef logic [BAL_W:0]   ext_t;

  localparam ext_t BAL_MAX = {1'b0, {BAL_W{1'b1}}};

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    cost_q;
  logic          ins_q;
`ifdef CARD_TERM_REFUND_EN
  logic          approved;
`endif

  logic ins_rise;
  logic approve;
  logic refund;
  ext_t bal_sum;
  bal_t bal_nxt;

  // Wide sum keeps top-up overflow visible before the clamp.
  always_comb begin
    ins_rise = CARD_INSERT & ~ins_q;
    approve  = (state == AUTH) && (cnt == '0) &&
               !INVALID_SELL &&
               (BALANCE >= bal_t'(cost_q));
`ifdef CARD_TERM_REFUND_EN
    refund   = (state == DONE) && approved &&
               FAILED_TRAN;
`else
    refund   = 1'b0;
`endif
    bal_sum = ext_t'(BALANCE);
    if (TOPUP)
      bal_sum = bal_sum + ext_t'(TOPUP_AMT);
    if (refund)
      bal_sum = bal_sum + ext_t'(cost_q);
    if (approve)
      bal_sum = bal_sum - ext_t'(cost_q);
    if (bal_sum > BAL_MAX)
      bal_nxt = BAL_MAX[BAL_W-1:0];
    else
      bal_nxt = bal_sum[BAL_W-1:0];
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= IDLE;
      cnt        <= '0;
      cost_q     <= '0;
      ins_q      <= 1'b0;
      CARD_IN    <= 1'b0;
      VALID_TRAN <= 1'b0;
      DECLINED   <= 1'b0;
      BUSY       <= 1'b0;
      BALANCE    <= bal_t'(START_BALANCE);
`ifdef CARD_TERM_REFUND_EN
      approved   <= 1'b0;
`endif
    end else begin
      ins_q      <= CARD_INSERT;
      CARD_IN    <= 1'b0;
      VALID_TRAN <= 1'b0;
      DECLINED   <= 1'b0;
      BALANCE    <= bal_nxt;
      unique case (state)
        IDLE: begin
          if (ins_rise) begin
            state   <= ARMED;
            cnt     <= '0;
            CARD_IN <= 1'b1;
            BUSY    <= 1'b1;
          end
        end
        ARMED: begin
          if (INVALID_SELL || FAILED_TRAN) begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end else if (COST != '0) begin
            cost_q <= COST;
            cnt    <= CW'(AUTH_DELAY - 1);
            state  <= AUTH;
          end else if (cnt == CW'(ARM_TIMEOUT - 1)) begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        AUTH: begin
          if (INVALID_SELL) begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end else if (cnt == '0) begin
            VALID_TRAN <= approve;
            DECLINED   <= ~approve;
            cnt        <= '0;
            state      <= DONE;
`ifdef CARD_TERM_REFUND_EN
            approved   <= approve;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (VEND || FAILED_TRAN || INVALID_SELL ||
              cnt == CW'(DONE_TO - 1)) begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_card_terminal.sv
// tb_card_terminal: directed + random stimulus for card_terminal,
// checked every cycle against a cycle-stamped session model.
module tb_card_terminal;

  localparam int START_BAL = 20;
  localparam int BAL_W     = 8;
  localparam int AD        = 2;
  localparam int AT        = 12;
  localparam int DT        = 16;
  localparam int BAL_MAX   = (1 << BAL_W) - 1;

  localparam int P_IDLE  = 0;
  localparam int P_ARMED = 1;
  localparam int P_AUTH  = 2;
  localparam int P_DONE  = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             card_insert = 1'b0;
  logic             topup = 1'b0;
  logic [3:0]       topup_amt = '0;
  logic [2:0]       cost = '0;
  logic             vend = 1'b0;
  logic             failed_tran = 1'b0;
  logic             invalid_sell = 1'b0;
  logic             card_in;
  logic             valid_tran;
  logic             declined;
  logic             busy;
  logic [BAL_W-1:0] balance;

  always #5 clk = ~clk;

  card_terminal #(
    .START_BALANCE(START_BAL),
    .BAL_W(BAL_W),
    .AUTH_DELAY(AD),
    .ARM_TIMEOUT(AT)
  ) dut (
    .CLK(clk),
    .RESET_N(rst_n),
    .CARD_INSERT(card_insert),
    .TOPUP(topup),
    .TOPUP_AMT(topup_amt),
    .COST(cost),
    .VEND(vend),
    .FAILED_TRAN(failed_tran),
    .INVALID_SELL(invalid_sell),
    .CARD_IN(card_in),
    .VALID_TRAN(valid_tran),
    .DECLINED(declined),
    .BUSY(busy),
    .BALANCE(balance)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Session model: phases plus cycle stamps of each milestone.
  int m_phase = P_IDLE;
  int m_bal   = START_BAL;
  int m_t     = 0;
  int m_tarm  = 0;
  int m_tcost = 0;
  int m_tdone = 0;
  int m_cost  = 0;
  bit m_prev  = 1'b0;
  bit m_appr  = 1'b0;
  bit e_cin   = 1'b0;
  bit e_vt    = 1'b0;
  bit e_dec   = 1'b0;

  task automatic model_step();
    int add;
    bit rise;
    if (!rst_n) begin
      m_phase = P_IDLE;
      m_bal   = START_BAL;
      m_prev  = 1'b0;
      m_appr  = 1'b0;
      e_cin   = 1'b0;
      e_vt    = 1'b0;
      e_dec   = 1'b0;
      return;
    end
    m_t++;
    e_cin = 1'b0;
    e_vt  = 1'b0;
    e_dec = 1'b0;
    add   = topup ? int'(topup_amt) : 0;
    rise  = card_insert && !m_prev;
    m_prev = card_insert;
    case (m_phase)
      P_IDLE: begin
        if (rise) begin
          m_phase = P_ARMED;
          m_tarm  = m_t;
          e_cin   = 1'b1;
        end
      end
      P_ARMED: begin
        if (invalid_sell || failed_tran) begin
          m_phase = P_IDLE;
        end else if (cost != 0) begin
          m_cost  = int'(cost);
          m_tcost = m_t;
          m_phase = P_AUTH;
        end else if (m_t - m_tarm == AT) begin
          m_phase = P_IDLE;
        end
      end
      P_AUTH: begin
        if (invalid_sell) begin
          m_phase = P_IDLE;
        end else if (m_t - m_tcost == AD) begin
          m_appr = (m_bal >= m_cost);
          if (m_appr) begin
            e_vt = 1'b1;
            add  = add - m_cost;
          end else begin
            e_dec = 1'b1;
          end
          m_phase = P_DONE;
          m_tdone = m_t;
        end
      end
      default: begin
`ifdef CARD_TERM_REFUND_EN
        if (failed_tran && m_appr)
          add = add + m_cost;
`endif
        if (vend || failed_tran || invalid_sell ||
            m_t - m_tdone == DT)
          m_phase = P_IDLE;
      end
    endcase
    m_bal = m_bal + add;
    if (m_bal > BAL_MAX)
      m_bal = BAL_MAX;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_card_in", int'(card_in), 0);
      chk("rst_valid", int'(valid_tran), 0);
      chk("rst_declined", int'(declined), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_balance", int'(balance), START_BAL);
    end else begin
      chk("card_in", int'(card_in), int'(e_cin));
      chk("valid_tran", int'(valid_tran), int'(e_vt));
      chk("declined", int'(declined), int'(e_dec));
      chk("busy", int'(busy), int'(m_phase != P_IDLE));
      chk("balance", int'(balance), m_bal);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic buy(input int c, input bit use_vend,
                     input bit topup_dec,
                     output bit vt, output bit dc);
    card_insert = 1'b1;
    tick();
    card_insert = 1'b0;
    cost = 3'(c);
    tick();
    cost = '0;
    repeat (AD - 1) tick();
    if (topup_dec) begin
      topup = 1'b1;
      topup_amt = 4'd15;
    end
    tick();
    topup = 1'b0;
    topup_amt = '0;
    vt = valid_tran;
    dc = declined;
    if (use_vend) begin
      vend = 1'b1;
      tick();
      vend = 1'b0;
    end
  endtask

  bit vt;
  bit dc;
  int p_cost;
  int p_end;

  initial begin
    repeat (3) tick();
    chk("lit_rst_balance", int'(balance), 20);
    chk("lit_rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    tick();

    // approval: insert, cost 3 two cycles later
    card_insert = 1'b1;
    tick();
    chk("lit_card_in_hi", int'(card_in), 1);
    chk("lit_busy_hi", int'(busy), 1);
    card_insert = 1'b0;
    tick();
    chk("lit_card_in_lo", int'(card_in), 0);
    tick();
    cost = 3'd3;
    tick();
    cost = 3'd6;
    tick();
    chk("lit_valid_early", int'(valid_tran), 0);
    tick();
    chk("lit_valid_hi", int'(valid_tran), 1);
    chk("lit_bal_17", int'(balance), 17);
    cost = '0;
    vend = 1'b1;
    tick();
    vend = 1'b0;
    chk("lit_vend_idle", int'(busy), 0);
    chk("lit_valid_one", int'(valid_tran), 0);

    // drain to 2, then decline and let DONE time out
    repeat (3) buy(5, 1'b1, 1'b0, vt, dc);
    chk("lit_bal_2", int'(balance), 2);
    buy(5, 1'b0, 1'b0, vt, dc);
    chk("lit_decl_vt", int'(vt), 0);
    chk("lit_decl_dc", int'(dc), 1);
    chk("lit_decl_bal", int'(balance), 2);
    repeat (DT - 1) tick();
    chk("lit_done_busy", int'(busy), 1);
    tick();
    chk("lit_done_to", int'(busy), 0);

    // saturating top-up with debit on the same edge
    topup = 1'b1;
    topup_amt = 4'd15;
    repeat (16) tick();
    topup_amt = 4'd8;
    tick();
    topup = 1'b0;
    topup_amt = '0;
    chk("lit_bal_250", int'(balance), 250);
    buy(4, 1'b1, 1'b1, vt, dc);
    chk("lit_sat_vt", int'(vt), 1);
    chk("lit_bal_255", int'(balance), 255);

    // invalid selection mid-AUTH
    card_insert = 1'b1;
    tick();
    card_insert = 1'b0;
    cost = 3'd3;
    tick();
    cost = '0;
    invalid_sell = 1'b1;
    tick();
    invalid_sell = 1'b0;
    chk("lit_abort_busy", int'(busy), 0);
    tick();
    chk("lit_abort_vt", int'(valid_tran), 0);
    chk("lit_abort_bal", int'(balance), 255);

    // arm timeout, with a second insert edge ignored
    card_insert = 1'b1;
    tick();
    card_insert = 1'b0;
    tick();
    card_insert = 1'b1;
    tick();
    chk("lit_reinsert", int'(card_in), 0);
    repeat (AT - 3) tick();
    chk("lit_arm_busy", int'(busy), 1);
    tick();
    chk("lit_arm_to", int'(busy), 0);
    tick();
    chk("lit_no_requeue", int'(busy), 0);
    card_insert = 1'b0;
    tick();

    // asynchronous reset mid-AUTH
    card_insert = 1'b1;
    tick();
    card_insert = 1'b0;
    cost = 3'd3;
    tick();
    cost = '0;
    rst_n = 1'b0;
    #1;
    chk("lit_arst_busy", int'(busy), 0);
    chk("lit_arst_bal", int'(balance), 20);
    chk("lit_arst_vt", int'(valid_tran), 0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("lit_arst_nopulse", int'(valid_tran), 0);

    // refund after approval
    buy(3, 1'b0, 1'b0, vt, dc);
    chk("lit_ref_vt", int'(vt), 1);
    chk("lit_ref_17", int'(balance), 17);
    failed_tran = 1'b1;
    tick();
    failed_tran = 1'b0;
`ifdef CARD_TERM_REFUND_EN
    chk("lit_refund", int'(balance), 20);
`else
    chk("lit_refund", int'(balance), 17);
`endif
    chk("lit_ref_idle", int'(busy), 0);

    // random traffic in blocks of varying density
    for (int b = 0; b < 15; b++) begin
      p_cost = (b % 2 == 0) ? 30 : 6;
      p_end  = (b % 3 == 0) ? 2 : 10;
      for (int i = 0; i < 200; i++) begin
        rst_n = ($urandom_range(0, 399) != 0);
        if ($urandom_range(0, 3) == 0)
          card_insert = ~card_insert;
        if ($urandom_range(0, 99) < p_cost)
          cost = 3'($urandom_range(1, 7));
        else
          cost = '0;
        topup = ($urandom_range(0, 39) == 0);
        topup_amt = 4'($urandom_range(0, 15));
        vend = ($urandom_range(0, 99) < p_end);
        failed_tran = ($urandom_range(0, 99) < p_end / 2);
        invalid_sell = ($urandom_range(0, 99) < p_end / 2);
        tick();
      end
    end
    rst_n = 1'b1;
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
